riscv_multicycle_core: RTL and testbench

//  Multi-cycle RV64I-subset core; successor to the single-cycle top. Width/reset-PC parametrised.
//  One FSM sequences fetch/decode/execute/memory/writeback over one internal regfile and ALU.

---
 rtl/riscv_multicycle_core_if.sv | 29 ++
 rtl/riscv_multicycle_core.sv | 184 ++++++++++++++++++
 tb/tb_riscv_multicycle_core.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_multicycle_core_if.sv
// Memory-side bus of riscv_multicycle_core: instruction fetch and data access
// handshakes. The core uses the master modport and the memory system uses slave.
interface riscv_multicycle_core_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  imem_req_out;
    logic [ADDR_WIDTH-1:0] imem_addr_out;
    logic                  imem_ready_in;
    logic [31:0]           imem_rdata_in;
    logic                  dmem_req_out;
    logic                  dmem_we_out;
    logic [ADDR_WIDTH-1:0] dmem_addr_out;
    logic [DATA_WIDTH-1:0] dmem_wdata_out;
    logic                  dmem_ready_in;
    logic [DATA_WIDTH-1:0] dmem_rdata_in;

    modport master (
        output imem_req_out, imem_addr_out, dmem_req_out, dmem_we_out,
               dmem_addr_out, dmem_wdata_out,
        input  imem_ready_in, imem_rdata_in, dmem_ready_in, dmem_rdata_in
    );

    modport slave (
        input  imem_req_out, imem_addr_out, dmem_req_out, dmem_we_out,
               dmem_addr_out, dmem_wdata_out,
        output imem_ready_in, imem_rdata_in, dmem_ready_in, dmem_rdata_in
    );
endinterface

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV64I-subset core (add/sub/and/or, addi, ld, sd, beq).
// One FSM walks FETCH -> DECODE -> EXEC -> {MEM -> WB | WB | FETCH}; any
// illegal instruction or misaligned access parks it in HALT until reset.
// Optional macro RISCV_PERF_CNT_EN adds cycle and retired-instruction counters.
module riscv_multicycle_core #(
    parameter int DATA_WIDTH_POW = 6,
    parameter int ADDR_WIDTH_POW = 6,
    parameter logic [(1<<ADDR_WIDTH_POW)-1:0] RESET_PC = '0
) (
    input  logic                              clk_in,
    input  logic                              reset,
    riscv_multicycle_core_if.master           bus,
    output logic [(1<<ADDR_WIDTH_POW)-1:0]    pc_out,
    output logic                              halted_out
`ifdef RISCV_PERF_CNT_EN
    ,
    output logic [63:0]                       cycle_cnt_out,
    output logic [63:0]                       instret_cnt_out
`endif
);
    localparam int DW = 1 << DATA_WIDTH_POW;
    localparam int AW = 1 << ADDR_WIDTH_POW;
    localparam int ALIGN_BITS = DATA_WIDTH_POW - 3;  // low address bits that must be 0 for ld/sd

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t          state, next_state;
    logic            started;        // low for the first cycle after reset, so no request rises during reset
    logic [AW-1:0]   pc, mem_addr;
    logic [31:0]     ir;
    logic [DW-1:0]   op_a, op_b, imm, res;
    logic [DW-1:0]   regs [0:31];    // regs[0] is never written and stays 0

    // instruction fields and legality, decoded straight from the latched IR
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    logic       is_r, is_addi, is_ld, is_sd, is_beq, legal;
    assign opcode  = ir[6:0];
    assign rd      = ir[11:7];
    assign funct3  = ir[14:12];
    assign rs1     = ir[19:15];
    assign rs2     = ir[24:20];
    assign funct7  = ir[31:25];
    assign is_r    = (opcode == 7'h33) &&
                     ((funct3 == 3'b000 && (funct7 == 7'h00 || funct7 == 7'h20)) ||
                      ((funct3 == 3'b111 || funct3 == 3'b110) && funct7 == 7'h00));
    assign is_addi = (opcode == 7'h13) && (funct3 == 3'b000);
    assign is_ld   = (opcode == 7'h03) && (funct3 == 3'b011);
    assign is_sd   = (opcode == 7'h23) && (funct3 == 3'b011);
    assign is_beq  = (opcode == 7'h63) && (funct3 == 3'b000);
    assign legal   = is_r | is_addi | is_ld | is_sd | is_beq;

    // immediate selection by format, sign-extended to the datapath width
    logic [11:0]   imm_i, imm_s;
    logic [12:0]   imm_b;
    logic [DW-1:0] imm_dec;
    assign imm_i   = ir[31:20];
    assign imm_s   = {ir[31:25], ir[11:7]};
    assign imm_b   = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_dec = is_sd  ? DW'($signed(imm_s)) :
                     is_beq ? DW'($signed(imm_b)) : DW'($signed(imm_i));

    // ALU, effective address and branch target used in EXEC
    logic [DW-1:0] alu_res;
    logic [AW-1:0] eff_addr, br_target, pc_plus4;
    logic          misaligned, br_taken, br_bad;
    always_comb begin
        alu_res = op_a + imm;
        if (is_r) begin
            case (funct3)
                3'b111:  alu_res = op_a & op_b;
                3'b110:  alu_res = op_a | op_b;
                default: alu_res = funct7[5] ? (op_a - op_b) : (op_a + op_b);
            endcase
        end
    end
    assign eff_addr   = AW'(alu_res);
    assign misaligned = |eff_addr[ALIGN_BITS-1:0];
    assign br_target  = pc + AW'(imm);
    assign pc_plus4   = pc + AW'(4);
    assign br_taken   = (op_a == op_b);
    assign br_bad     = br_taken && (|br_target[1:0]);

    // state register
    always_ff @(posedge clk_in) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // next-state and handshake outputs
    logic imem_req, dmem_req, dmem_we;
    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = started;
                if (started && bus.imem_ready_in) next_state = S_DECODE;
            end
            S_DECODE: next_state = legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (is_beq)              next_state = br_bad ? S_HALT : S_FETCH;
                else if (is_ld || is_sd) next_state = misaligned ? S_HALT : S_MEM;
                else                     next_state = S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sd;
                if (bus.dmem_ready_in) next_state = is_sd ? S_FETCH : S_WB;
            end
            S_WB:    next_state = S_FETCH;
            default: next_state = S_HALT;
        endcase
    end

    // datapath: PC, IR, operands, result and register file
    always_ff @(posedge clk_in) begin
        if (reset) begin
            pc       <= RESET_PC;
            started  <= 1'b0;
            ir       <= '0;
            op_a     <= '0;
            op_b     <= '0;
            imm      <= '0;
            res      <= '0;
            mem_addr <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            started <= 1'b1;
            case (state)
                S_FETCH:  if (started && bus.imem_ready_in) ir <= bus.imem_rdata_in;
                S_DECODE: begin
                    op_a <= regs[rs1];
                    op_b <= regs[rs2];
                    imm  <= imm_dec;
                end
                S_EXEC: begin
                    res <= alu_res;
                    if (next_state == S_MEM) mem_addr <= eff_addr;
                    if (is_beq && !br_bad)   pc <= br_taken ? br_target : pc_plus4;
                end
                S_MEM: begin
                    if (bus.dmem_ready_in) begin
                        if (is_sd) pc  <= pc_plus4;
                        else       res <= bus.dmem_rdata_in;
                    end
                end
                S_WB: begin
                    if (rd != 5'd0) regs[rd] <= res;
                    pc <= pc_plus4;
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_req_out   = imem_req;
    assign bus.imem_addr_out  = pc;
    assign bus.dmem_req_out   = dmem_req;
    assign bus.dmem_we_out    = dmem_we;
    assign bus.dmem_addr_out  = mem_addr;
    assign bus.dmem_wdata_out = op_b;
    assign pc_out             = pc;
    assign halted_out         = (state == S_HALT);

`ifdef RISCV_PERF_CNT_EN
    // cycle counter runs every non-reset cycle; instret bumps when an instruction completes
    logic retire;
    assign retire = (state == S_WB) ||
                    ((state == S_MEM || state == S_EXEC) && next_state == S_FETCH);
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cycle_cnt_out   <= '0;
            instret_cnt_out <= '0;
        end else begin
            cycle_cnt_out <= cycle_cnt_out + 64'd1;
            if (retire) instret_cnt_out <= instret_cnt_out + 64'd1;
        end
    end
`endif
endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core: behavioural instruction/data memories
// with programmable wait states, hand-computed expectations checked by assertions.
module tb_riscv_multicycle_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    riscv_multicycle_core_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus();
    logic [63:0] pc;
    logic        halted;
`ifdef RISCV_PERF_CNT_EN
    logic [63:0] cyc, ins;
`endif

    riscv_multicycle_core dut (
        .clk_in(clk), .reset(reset), .bus(bus.master), .pc_out(pc), .halted_out(halted)
`ifdef RISCV_PERF_CNT_EN
        , .cycle_cnt_out(cyc), .instret_cnt_out(ins)
`endif
    );

    localparam logic [31:0] ILL = 32'h0000_007F;

    // memory models
    logic [31:0] imem [0:63];
    logic [63:0] dmem [0:63];
    int imem_wait = 0, dmem_wait = 0;
    int iw, dw;
    logic clr = 1'b1, pre_we = 1'b0;
    int pre_idx = 0;
    logic [63:0] pre_val = '0;
    int flen_min, flen_max, st_cnt;
    logic addr_moved, dreq_seen;
    logic [63:0] prev_iaddr, st_addr, st_wdata;

    assign bus.imem_ready_in = bus.imem_req_out && (iw >= imem_wait);
    assign bus.imem_rdata_in = imem[bus.imem_addr_out[7:2]];
    assign bus.dmem_ready_in = bus.dmem_req_out && (dw >= dmem_wait);
    assign bus.dmem_rdata_in = dmem[bus.dmem_addr_out[8:3]];

    always @(posedge clk) begin
        if (pre_we) dmem[pre_idx] <= pre_val;
        else if (bus.dmem_req_out && bus.dmem_ready_in && bus.dmem_we_out)
            dmem[bus.dmem_addr_out[8:3]] <= bus.dmem_wdata_out;
        prev_iaddr <= bus.imem_addr_out;
        if (clr) begin
            iw <= 0; dw <= 0; flen_min <= 999; flen_max <= 0; st_cnt <= 0;
            addr_moved <= 1'b0; dreq_seen <= 1'b0; st_addr <= '0; st_wdata <= '0;
        end else begin
            if (bus.imem_req_out) begin
                if (iw > 0 && bus.imem_addr_out != prev_iaddr) addr_moved <= 1'b1;
                if (bus.imem_ready_in) begin
                    iw <= 0;
                    if (iw + 1 < flen_min) flen_min <= iw + 1;
                    if (iw + 1 > flen_max) flen_max <= iw + 1;
                end else iw <= iw + 1;
            end else iw <= 0;
            if (bus.dmem_req_out) begin
                dreq_seen <= 1'b1;
                if (bus.dmem_ready_in) begin
                    dw <= 0;
                    if (bus.dmem_we_out) begin
                        st_cnt <= st_cnt + 1;
                        if (st_cnt == 0) begin
                            st_addr  <= bus.dmem_addr_out;
                            st_wdata <= bus.dmem_wdata_out;
                        end
                    end
                end else dw <= dw + 1;
            end else dw <= 0;
        end
    end

    // instruction encoders
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b011, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] addi(int rd, int rs1, int imm); return enc_i(imm, rs1, 0, rd, 7'h13); endfunction
    function automatic logic [31:0] ld(int rd, int rs1, int imm);   return enc_i(imm, rs1, 3, rd, 7'h03); endfunction

    int n_vec = 0, n_err = 0;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = ILL;
    endtask

    task automatic preload(input int idx, input logic [63:0] val);
        pre_idx = idx; pre_val = val; pre_we = 1'b1;
        step();
        pre_we = 1'b0;
    endtask

    task automatic enter_reset();
        reset = 1'b1; clr = 1'b1;
        step(); step();
    endtask

    task automatic release_reset();
        clr = 1'b0; reset = 1'b0;
        step();
    endtask

    task automatic run_halt(input string tag, input int maxc);
        for (int i = 0; i < maxc && halted !== 1'b1; i++) step();
        chk({tag, "_halt"}, 64'(halted), 64'd1);
    endtask

    initial begin
        // ---- reset state and first request ----
        clear_imem();
        imem[0] = addi(1, 0, 5);
        imem[1] = addi(2, 1, -7);
        imem[2] = enc_s(0, 1, 0);
        imem[3] = enc_s(8, 2, 0);
        enter_reset();
        chk("rst_ireq", 64'(bus.imem_req_out), 64'd0);
        chk("rst_dreq", 64'(bus.dmem_req_out), 64'd0);
        chk("rst_we", 64'(bus.dmem_we_out), 64'd0);
        chk("rst_halt", 64'(halted), 64'd0);
        chk("rst_pc", pc, 64'd0);
        chk("rst_daddr", bus.dmem_addr_out, 64'd0);
        chk("rst_wdata", bus.dmem_wdata_out, 64'd0);
`ifdef RISCV_PERF_CNT_EN
        chk("rst_cyc", cyc, 64'd0);
        chk("rst_ins", ins, 64'd0);
`endif
        release_reset();
        chk("first_ireq", 64'(bus.imem_req_out), 64'd1);

        // ---- zero-wait addi pair ----
        for (int i = 0; i < 8; i++) step();
        chk("addi_pc8", pc, 64'd8);
        run_halt("addi", 100);
        chk("addi_x1", dmem[0], 64'd5);
        chk("addi_x2", dmem[1], 64'hFFFF_FFFF_FFFF_FFFE);
        chk("addi_pcend", pc, 64'd16);
        chk("addi_flen", 64'(flen_max), 64'd1);
`ifdef RISCV_PERF_CNT_EN
        chk("addi_ins", ins, 64'd4);
`endif

        // ---- same program with 3 fetch wait states ----
        enter_reset();
        preload(0, 64'd0); preload(1, 64'd0);
        imem_wait = 3;
        release_reset();
        run_halt("wait", 300);
        chk("wait_flen_min", 64'(flen_min), 64'd4);
        chk("wait_flen_max", 64'(flen_max), 64'd4);
        chk("wait_addr_stable", 64'(addr_moved), 64'd0);
        chk("wait_x1", dmem[0], 64'd5);
        chk("wait_x2", dmem[1], 64'hFFFF_FFFF_FFFF_FFFE);
        chk("wait_pc", pc, 64'd16);
        imem_wait = 0;

        // ---- R-type ALU, x0 discard ----
        enter_reset();
        preload(5, 64'h55);
        clear_imem();
        imem[0]  = addi(1, 0, 12);
        imem[1]  = addi(2, 0, 10);
        imem[2]  = enc_r(7'h00, 2, 1, 0, 3);
        imem[3]  = enc_r(7'h20, 2, 1, 0, 4);
        imem[4]  = enc_r(7'h00, 2, 1, 7, 5);
        imem[5]  = enc_r(7'h00, 2, 1, 6, 6);
        imem[6]  = enc_r(7'h20, 1, 2, 0, 7);
        imem[7]  = addi(0, 0, 9);
        imem[8]  = enc_s(0, 3, 0);
        imem[9]  = enc_s(8, 4, 0);
        imem[10] = enc_s(16, 5, 0);
        imem[11] = enc_s(24, 6, 0);
        imem[12] = enc_s(32, 7, 0);
        imem[13] = enc_s(40, 0, 0);
        release_reset();
        run_halt("alu", 300);
        chk("alu_add", dmem[0], 64'd22);
        chk("alu_sub", dmem[1], 64'd2);
        chk("alu_and", dmem[2], 64'd8);
        chk("alu_or", dmem[3], 64'd14);
        chk("alu_sub_wrap", dmem[4], 64'hFFFF_FFFF_FFFF_FFFE);
        chk("alu_x0", dmem[5], 64'd0);
        chk("alu_pc", pc, 64'h38);

        // ---- sd/ld round trip with data wait states ----
        enter_reset();
        preload(0, 64'hDEAD_BEEF);
        clear_imem();
        imem[0] = ld(2, 0, 0);
        imem[1] = addi(1, 0, 256);
        imem[2] = enc_s(8, 2, 1);
        imem[3] = ld(3, 1, 8);
        imem[4] = enc_s(16, 3, 0);
        dmem_wait = 2;
        release_reset();
        run_halt("mem", 300);
        chk("mem_st_addr", st_addr, 64'h108);
        chk("mem_st_wdata", st_wdata, 64'hDEAD_BEEF);
        chk("mem_st_cnt", 64'(st_cnt), 64'd2);
        chk("mem_dmem108", dmem[33], 64'hDEAD_BEEF);
        chk("mem_x3", dmem[2], 64'hDEAD_BEEF);
        dmem_wait = 0;

        // ---- beq taken backwards ----
        enter_reset();
        clear_imem();
        imem[0] = enc_b(16, 0, 0);
        imem[4] = enc_b(-4, 0, 0);
        release_reset();
        run_halt("beq_t", 100);
        chk("beq_t_pc", pc, 64'h0C);
`ifdef RISCV_PERF_CNT_EN
        chk("beq_t_ins", ins, 64'd2);
`endif

        // ---- beq not taken ----
        enter_reset();
        clear_imem();
        imem[0] = addi(1, 0, 1);
        imem[1] = enc_b(12, 0, 0);
        imem[4] = enc_b(-4, 0, 1);
        release_reset();
        run_halt("beq_nt", 100);
        chk("beq_nt_pc", pc, 64'h14);

        // ---- beq to misaligned target ----
        enter_reset();
        clear_imem();
        imem[0] = enc_b(6, 0, 0);
        release_reset();
        run_halt("beq_mis", 50);
        chk("beq_mis_pc", pc, 64'd0);

        // ---- illegal opcode: halts two cycles after fetch ----
        enter_reset();
        clear_imem();
        release_reset();
        step(); step();
        chk("ill_halt", 64'(halted), 64'd1);
        chk("ill_pc", pc, 64'd0);
`ifdef RISCV_PERF_CNT_EN
        chk("ill_cyc3", cyc, 64'd3);
`endif
        step(); step(); step();
        chk("ill_noreq", 64'(bus.imem_req_out), 64'd0);
        chk("ill_pc_frozen", pc, 64'd0);
`ifdef RISCV_PERF_CNT_EN
        chk("ill_cyc6", cyc, 64'd6);
        chk("ill_ins", ins, 64'd0);
`endif

        // ---- illegal funct7 on AND ----
        enter_reset();
        clear_imem();
        imem[0] = enc_r(7'h20, 2, 1, 7, 3);
        release_reset();
        run_halt("f7", 50);
        chk("f7_pc", pc, 64'd0);

        // ---- misaligned load issues no request ----
        enter_reset();
        clear_imem();
        imem[0] = ld(3, 0, 3);
        release_reset();
        run_halt("ldmis", 50);
        chk("ldmis_noreq", 64'(dreq_seen), 64'd0);
        chk("ldmis_pc", pc, 64'd0);

        // ---- reset while a store is outstanding ----
        enter_reset();
        preload(0, 64'h33);
        preload(1, 64'h55);
        clear_imem();
        imem[0] = addi(1, 0, 7);
        imem[1] = enc_s(0, 1, 0);
        dmem_wait = 100;
        release_reset();
        for (int i = 0; i < 50 && bus.dmem_req_out !== 1'b1; i++) step();
        chk("mid_dreq_up", 64'(bus.dmem_req_out), 64'd1);
        reset = 1'b1;
        step();
        chk("mid_dreq_drop", 64'(bus.dmem_req_out), 64'd0);
        chk("mid_ireq", 64'(bus.imem_req_out), 64'd0);
        chk("mid_pc", pc, 64'd0);
`ifdef RISCV_PERF_CNT_EN
        chk("mid_cyc", cyc, 64'd0);
        chk("mid_ins", ins, 64'd0);
`endif
        clr = 1'b1;
        step();
        dmem_wait = 0;
        clear_imem();
        imem[0] = enc_s(8, 1, 0);
        release_reset();
        run_halt("mid", 50);
        chk("mid_x1_cleared", dmem[1], 64'd0);
        chk("mid_abandoned", dmem[0], 64'h33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
